// File: rtl/oversample_tx_serializer.sv
// Oversampling TX serializer: LSB-first words, each bit replicated OSR times into a SW_W-bit window per clk.
// Optional PRBS7 payload mode is compiled in when TX_PRBS_EN is defined (adds the prbs_mode port).
module oversample_tx_serializer #(
  parameter int              OSR       = 4,
  parameter int              SW_W      = 8,
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_WORD = 8'hBC,
  parameter bit              INVERT    = 1'b0
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              tx_en,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
`ifdef TX_PRBS_EN
  input  logic              prbs_mode,
`endif
  output logic              s_ready,
  output logic [SW_W-1:0]   sample_window,
  output logic              busy
);

  localparam int BPC   = SW_W / OSR;
  localparam int BEATS = DATA_W / BPC;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA} state_t;

  function automatic logic [BPC-1:0] idle_bits();
    logic [BPC-1:0] r;
    for (int b = 0; b < BPC; b++) r[b] = ((b % 2) == 0);
    return r;
  endfunction

  function automatic logic [SW_W-1:0] expand(input logic [BPC-1:0] bits);
    logic [SW_W-1:0] w;
    w = '0;
    for (int b = 0; b < BPC; b++) w[b*OSR +: OSR] = {OSR{bits[b]}};
    return w;
  endfunction

  localparam logic [BPC-1:0] IDLE_BITS = idle_bits();

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic [SW_W-1:0]   sample_window_q, sample_window_d;
  logic              busy_q, busy_d;
  logic [BPC-1:0]    win_bits;
  logic [SW_W-1:0]   win_raw;

`ifdef TX_PRBS_EN
  logic [6:0]        prbs_q, prbs_d, prbs_s;
  logic [BPC-1:0]    prbs_bits;
  logic              prbs_word_q, prbs_word_d;

  assign s_ready = ~hold_valid_q & ~areset & ~prbs_mode;
`else
  assign s_ready = ~hold_valid_q & ~areset;
`endif

  assign sample_window = sample_window_q;
  assign busy          = busy_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q         <= ST_IDLE;
      beat_q          <= '0;
      shreg_q         <= '0;
      hold_q          <= '0;
      hold_valid_q    <= 1'b0;
      sample_window_q <= {SW_W{INVERT}};
      busy_q          <= 1'b0;
`ifdef TX_PRBS_EN
      prbs_q          <= 7'h7F;
      prbs_word_q     <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      shreg_q         <= shreg_d;
      hold_q          <= hold_d;
      hold_valid_q    <= hold_valid_d;
      sample_window_q <= sample_window_d;
      busy_q          <= busy_d;
`ifdef TX_PRBS_EN
      prbs_q          <= prbs_d;
      prbs_word_q     <= prbs_word_d;
`endif
    end
  end

  // State, beat and shreg describe the beat that the window register shows after this edge.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    win_bits     = '0;
    win_raw      = '0;
`ifdef TX_PRBS_EN
    prbs_word_d  = prbs_word_q;
    prbs_d       = prbs_q;
    prbs_s       = prbs_q;
    prbs_bits    = '0;
    for (int b = 0; b < BPC; b++) begin
      prbs_bits[b] = prbs_s[6] ^ prbs_s[5];
      prbs_s       = {prbs_s[5:0], prbs_bits[b]};
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (tx_en && hold_valid_q) begin
          state_d = ST_SYNC;
          beat_d  = '0;
          shreg_d = SYNC_WORD;
        end
      end
      ST_SYNC: begin
        if (beat_q == LAST_BEAT) begin
          state_d      = ST_DATA;
          beat_d       = '0;
          shreg_d      = hold_q;
          hold_valid_d = 1'b0;
        end else begin
          beat_d  = beat_q + CNT_W'(1);
          shreg_d = shreg_q >> BPC;
        end
      end
      ST_DATA: begin
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
          if (hold_valid_q && tx_en) begin
            shreg_d      = hold_q;
            hold_valid_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          beat_d  = beat_q + CNT_W'(1);
          shreg_d = shreg_q >> BPC;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase

    if (s_valid && s_ready) begin
      hold_d       = s_data;
      hold_valid_d = 1'b1;
    end

`ifdef TX_PRBS_EN
    // PRBS words only start on a word boundary; the held word is left untouched.
    if (prbs_mode && (state_q != ST_DATA || beat_q == LAST_BEAT)) begin
      state_d      = ST_DATA;
      beat_d       = '0;
      shreg_d      = shreg_q;
      hold_valid_d = hold_valid_q;
      prbs_word_d  = 1'b1;
    end else if (!prbs_mode && prbs_word_q && beat_q == LAST_BEAT) begin
      prbs_word_d = 1'b0;
    end
`endif

    win_bits = shreg_d[BPC-1:0];
`ifdef TX_PRBS_EN
    if (prbs_word_d && state_d == ST_DATA) begin
      win_bits = prbs_bits;
      prbs_d   = prbs_s;
    end
`endif

    if (state_d == ST_IDLE) win_raw = expand(IDLE_BITS);
    else                    win_raw = expand(win_bits);

    sample_window_d = win_raw ^ {SW_W{INVERT}};
    busy_d          = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_oversample_tx_serializer.sv
// Scoreboard bench: a line-level reference model queues the expected window per clock;
// a negedge monitor pops and compares both a normal and an INVERT=1 instance.
module tb_oversample_tx_serializer;

  localparam int OSR = 4;
  localparam int SW_W = 8;
  localparam int BPC = SW_W / OSR;
  localparam int BEATS = 8 / BPC;
  localparam logic [7:0] SYNC = 8'hBC;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       tx_en = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       prbs_mode = 1'b0;
  logic       rdy0, rdy1, busy0, busy1;
  logic [7:0] sw0, sw1;

  always #5 clk = ~clk;

  oversample_tx_serializer #(.OSR(4), .SW_W(8), .DATA_W(8), .SYNC_WORD(8'hBC), .INVERT(1'b0)) dut (
    .clk(clk), .areset(areset), .tx_en(tx_en), .s_data(s_data), .s_valid(s_valid),
`ifdef TX_PRBS_EN
    .prbs_mode(prbs_mode),
`endif
    .s_ready(rdy0), .sample_window(sw0), .busy(busy0));

  oversample_tx_serializer #(.OSR(4), .SW_W(8), .DATA_W(8), .SYNC_WORD(8'hBC), .INVERT(1'b1)) dut_inv (
    .clk(clk), .areset(areset), .tx_en(tx_en), .s_data(s_data), .s_valid(s_valid),
`ifdef TX_PRBS_EN
    .prbs_mode(prbs_mode),
`endif
    .s_ready(rdy1), .sample_window(sw1), .busy(busy1));

  typedef struct packed {logic [7:0] w; logic b; logic r;} exp_t;
  typedef struct {logic [7:0] w; bit rel;} beat_t;

  exp_t       exp_q[$];
  beat_t      pend[$];
  logic [7:0] obs_log[$];
  int         checks = 0;
  int         errors = 0;

  bit         m_hold_v, m_busy, m_acc;
  logic [7:0] m_hold;

  // Window for beat i of a word: sample s carries word bit i*BPC + s/OSR.
  function automatic logic [7:0] beat_win(input logic [7:0] word, input int i);
    logic [7:0] w;
    for (int s = 0; s < SW_W; s++) w[s] = word[i*BPC + s/OSR];
    return w;
  endfunction

  function automatic logic [7:0] idle_win();
    logic [7:0] w;
    for (int s = 0; s < SW_W; s++) w[s] = ((s / OSR) % 2 == 0);
    return w;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_hold_v = 0; m_busy = 0; m_acc = 0; pend.delete();
  endtask

  // One clock edge of the reference model, using the inputs present at the edge.
  task automatic model_edge();
    logic [7:0] w;
    bit busy_n, acc;
    beat_t e;
    if (areset) begin
      m_reset();
      exp_q.push_back('{w: 8'h00, b: 1'b0, r: 1'b0});
      return;
    end
    acc = s_valid && !m_hold_v;
    if (pend.size() > 0) begin
      e = pend.pop_front();
      w = e.w;
      if (e.rel) m_hold_v = 0;
      busy_n = 1;
    end else if (tx_en && m_hold_v) begin
      if (!m_busy) begin
        w = beat_win(SYNC, 0);
        for (int i = 1; i < BEATS; i++) pend.push_back('{w: beat_win(SYNC, i), rel: 1'b0});
        for (int i = 0; i < BEATS; i++) pend.push_back('{w: beat_win(m_hold, i), rel: (i == 0)});
      end else begin
        w = beat_win(m_hold, 0);
        m_hold_v = 0;
        for (int i = 1; i < BEATS; i++) pend.push_back('{w: beat_win(m_hold, i), rel: 1'b0});
      end
      busy_n = 1;
    end else begin
      w = idle_win();
      busy_n = 0;
    end
    if (acc) begin
      m_hold_v = 1;
      m_hold = s_data;
    end
    m_acc = acc;
    m_busy = busy_n;
    exp_q.push_back('{w: w, b: busy_n, r: !m_hold_v});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic assert_reset();
    areset = 1'b1;
    exp_q.delete();
    m_reset();
    exp_q.push_back('{w: 8'h00, b: 1'b0, r: 1'b0});
  endtask

  task automatic release_reset();
    tick();
    areset = 1'b0;
    exp_q.delete();
    exp_q.push_back('{w: 8'h00, b: 1'b0, r: 1'b1});
  endtask

  task automatic offer(input bit tx, input logic [7:0] d);
    tx_en = tx; s_valid = 1'b1; s_data = d;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (m_acc) break;
    end
    s_valid = 1'b0;
    checks++;
    if (!m_acc) begin
      errors++;
      $display("FAIL offer_timeout: word %02h not accepted within 200 cycles", d);
    end
  endtask

  // Monitor: one scoreboard entry per clock, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      obs_log.push_back(sw0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("window", sw0, e.w);
        chk("window_inv", sw1, ~e.w);
        chk("busy", {7'b0, busy0}, {7'b0, e.b});
        chk("busy_inv", {7'b0, busy1}, {7'b0, e.b});
        chk("s_ready", {7'b0, rdy0}, {7'b0, e.r});
        chk("s_ready_inv", {7'b0, rdy1}, {7'b0, e.r});
      end
    end
  end

  initial begin
    logic [7:0] lit [11];
    lit = '{8'h0F, 8'h0F, 8'h00, 8'hFF, 8'hFF, 8'hF0, 8'h0F, 8'h0F, 8'hF0, 8'hF0, 8'h0F};

    m_reset();
    repeat (3) tick();
    tx_en = 1'b1;
    release_reset();
    repeat (4) tick();

    // Single A5 from idle, also checked against literal line windows.
    tx_en = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    obs_log.delete();
    tick();
    s_valid = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 11; i++) begin
      if (i < obs_log.size()) chk($sformatf("lit_a5_%0d", i), obs_log[i], lit[i]);
      else chk($sformatf("lit_a5_missing_%0d", i), 8'hXX, lit[i]);
    end

    // Back-to-back words: one sync, then chained data.
    offer(1'b1, 8'hA5);
    offer(1'b1, 8'h3C);
    repeat (12) tick();

    // Word queued with tx_en low stays held until tx_en returns.
    offer(1'b0, 8'h5A);
    repeat (5) tick();
    tx_en = 1'b1;
    repeat (12) tick();

    // Reset during data beat 2, then a fresh burst.
    offer(1'b1, 8'hC3);
    repeat (BEATS + 2) tick();
    assert_reset();
    release_reset();
    offer(1'b1, 8'h96);
    repeat (12) tick();

    // Randomized traffic, tx_en toggling and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!s_valid || m_acc) begin
        s_valid = ($urandom_range(0, 2) == 0);
        s_data = 8'($urandom);
      end
      tx_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 299) == 0) begin
        assert_reset();
        release_reset();
      end
    end
    s_valid = 1'b0;
    tx_en = 1'b1;
    repeat (12) tick();

    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
